// File: rtl/timer_core_if.sv
// Register-strobe bus between the bus adapter and the timer core.
interface timer_core_if;
  logic [3:0]       write_en;
  logic [3:0]       read_en;
  logic [31:0]      data_in;
  logic [3:0][31:0] data_out;
  logic             irq_out;

  modport master (
    output write_en,
    output read_en,
    output data_in,
    input  data_out,
    input  irq_out
  );

  modport slave (
    input  write_en,
    input  read_en,
    input  data_in,
    output data_out,
    output irq_out
  );
endinterface

// File: rtl/timer_core.sv
// Prescaled down-counting timer: CTRL/LOAD/COUNT/STATUS,
// sticky expiry flag and registered level interrupt.
module timer_core #(
  parameter int unsigned PRESCALE   = 1,
  parameter logic [31:0] RESET_LOAD = 32'h0
) (
  input logic         clk,
  input logic         reset_n,
  timer_core_if.slave bus
);

  localparam int unsigned PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [2:0]    r_ctrl;
  logic [31:0]   r_load;
  logic [31:0]   r_count;
  logic          r_expired;
  logic          r_clr_pend;
  logic          r_irq;
  logic [PW-1:0] r_psc;

  logic [2:0]    w_ctrl_nxt;
  logic [31:0]   w_load_nxt;
  logic [31:0]   w_count_nxt;
  logic          w_expired_nxt;
  logic          w_irq_nxt;
  logic [PW-1:0] w_psc_nxt;
  logic          w_tick;
  logic          w_expire;
  logic          w_clr;
  logic          w_unused;

  assign w_unused = ^{bus.read_en[2:0]};

  always_comb begin
    w_ctrl_nxt    = r_ctrl;
    w_load_nxt    = r_load;
    w_count_nxt   = r_count;
    w_expired_nxt = r_expired;
    w_psc_nxt     = r_psc;

    w_tick   = r_ctrl[0] && (r_psc == PMAX);
    // A COUNT write swallows a coincident tick entirely
    w_expire = w_tick && !bus.write_en[2]
             && (r_count == 32'h0);
    w_clr    = r_clr_pend
             || (bus.write_en[3] && bus.data_in[0]);

    // Disabled (incl. the enabling write) holds phase at 0
    if (!r_ctrl[0] || w_tick) begin
      w_psc_nxt = '0;
    end else begin
      w_psc_nxt = r_psc + 1'b1;
    end

    if (bus.write_en[0]) begin
      w_ctrl_nxt = bus.data_in[2:0];
    end else if (w_expire && !r_ctrl[1]) begin
      w_ctrl_nxt[0] = 1'b0;
    end

    if (bus.write_en[1]) begin
      w_load_nxt = bus.data_in;
    end

    if (bus.write_en[2]) begin
      w_count_nxt = bus.data_in;
    end else if (w_tick) begin
      if (r_count != 32'h0) begin
        w_count_nxt = r_count - 32'h1;
      end else if (r_ctrl[1]) begin
        w_count_nxt = r_load;
      end
    end

    if (w_expire) begin
      w_expired_nxt = 1'b1;
    end else if (w_clr) begin
      w_expired_nxt = 1'b0;
    end

    w_irq_nxt = w_expired_nxt & w_ctrl_nxt[2];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl     <= 3'b000;
      r_load     <= RESET_LOAD;
      r_count    <= RESET_LOAD;
      r_expired  <= 1'b0;
      r_clr_pend <= 1'b0;
      r_irq      <= 1'b0;
      r_psc      <= '0;
    end else begin
      r_ctrl     <= w_ctrl_nxt;
      r_load     <= w_load_nxt;
      r_count    <= w_count_nxt;
      r_expired  <= w_expired_nxt;
      r_clr_pend <= bus.read_en[3];
      r_irq      <= w_irq_nxt;
      r_psc      <= w_psc_nxt;
    end
  end

  assign bus.data_out[0] = {29'h0, r_ctrl};
  assign bus.data_out[1] = r_load;
  assign bus.data_out[2] = r_count;
  assign bus.data_out[3] = {31'h0, r_expired};
  assign bus.irq_out     = r_irq;

endmodule

// File: tb/tb_timer_core.sv
// Self-checking bench for timer_core: vector table,
// PRESCALE=4 period sequences, async reset, random vs model.
module tb_timer_core;

  logic clk;
  logic reset_n;

  timer_core_if if1 ();
  timer_core_if if4 ();

  timer_core #(.PRESCALE(1), .RESET_LOAD(32'h0)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(if1.slave)
  );
  timer_core #(.PRESCALE(4), .RESET_LOAD(32'h5)) u4 (
    .clk(clk), .reset_n(reset_n), .bus(if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit [2:0]  ctrl;
    bit [31:0] load;
    bit [31:0] count;
    bit        expd;
    bit        pend;
    int        psc;
  } model_t;

  model_t m1, m4;

  function automatic model_t mreset(bit [31:0] rl);
    model_t n;
    n.ctrl  = 3'b000;
    n.load  = rl;
    n.count = rl;
    n.expd  = 1'b0;
    n.pend  = 1'b0;
    n.psc   = 0;
    return n;
  endfunction

  // Behavioural register-map model, one call per clock
  function automatic model_t mstep(model_t m, int p,
      bit [3:0] we, bit [3:0] re, bit [31:0] d);
    model_t n;
    bit tick, zero, expire;
    n      = m;
    tick   = m.ctrl[0] && (m.psc == p - 1);
    zero   = (m.count == 0);
    expire = tick && zero && !we[2];
    n.psc  = m.ctrl[0] ? (m.psc + 1) % p : 0;
    if (we[2]) n.count = d;
    else if (tick && !zero) n.count = m.count - 1;
    else if (expire && m.ctrl[1]) n.count = m.load;
    if (we[0]) n.ctrl = d[2:0];
    else if (expire && !m.ctrl[1]) n.ctrl[0] = 1'b0;
    if (we[1]) n.load = d;
    if (expire) n.expd = 1'b1;
    else if (m.pend || (we[3] && d[0])) n.expd = 1'b0;
    n.pend = re[3];
    return n;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cmp_all();
    chk("m1 ctrl",  if1.data_out[0], {29'h0, m1.ctrl});
    chk("m1 load",  if1.data_out[1], m1.load);
    chk("m1 count", if1.data_out[2], m1.count);
    chk("m1 stat",  if1.data_out[3], {31'h0, m1.expd});
    chk("m1 irq",   {31'h0, if1.irq_out},
        {31'h0, m1.expd & m1.ctrl[2]});
    chk("m4 ctrl",  if4.data_out[0], {29'h0, m4.ctrl});
    chk("m4 load",  if4.data_out[1], m4.load);
    chk("m4 count", if4.data_out[2], m4.count);
    chk("m4 stat",  if4.data_out[3], {31'h0, m4.expd});
    chk("m4 irq",   {31'h0, if4.irq_out},
        {31'h0, m4.expd & m4.ctrl[2]});
  endtask

  task automatic drive(bit [3:0] we, bit [3:0] re,
                       bit [31:0] d);
    if1.write_en = we; if1.read_en = re; if1.data_in = d;
    if4.write_en = we; if4.read_en = re; if4.data_in = d;
  endtask

  task automatic step(bit [3:0] we, bit [3:0] re,
                      bit [31:0] d);
    drive(we, re, d);
    @(posedge clk);
    #1;
    m1 = mstep(m1, 1, we, re, d);
    m4 = mstep(m4, 4, we, re, d);
    drive(4'h0, 4'h0, 32'h0);
    cmp_all();
  endtask

  task automatic do_reset();
    drive(4'h0, 4'h0, 32'h0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m1 = mreset(32'h0);
    m4 = mreset(32'h5);
    cmp_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit [3:0]  we;
    bit [3:0]  re;
    bit [31:0] din;
    bit [2:0]  ctrl;
    bit [31:0] count;
    bit        expd;
    bit        irq;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t mk(bit [3:0] we, bit [3:0] re,
      bit [31:0] din, bit [2:0] c, bit [31:0] n,
      bit e, bit q);
    vec_t v;
    v.we = we; v.re = re; v.din = din;
    v.ctrl = c; v.count = n; v.expd = e; v.irq = q;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(4'b0110, 4'h0, 3,   3'd0, 3,   0, 0);
    tbl[1]  = mk(4'b0001, 4'h0, 7,   3'd7, 3,   0, 0);
    tbl[2]  = mk(4'h0,    4'h0, 0,   3'd7, 2,   0, 0);
    tbl[3]  = mk(4'h0,    4'h0, 0,   3'd7, 1,   0, 0);
    tbl[4]  = mk(4'h0,    4'h0, 0,   3'd7, 0,   0, 0);
    tbl[5]  = mk(4'h0,    4'h0, 0,   3'd7, 3,   1, 1);
    tbl[6]  = mk(4'h0,    4'h0, 0,   3'd7, 2,   1, 1);
    tbl[7]  = mk(4'h0,    4'h8, 0,   3'd7, 1,   1, 1);
    tbl[8]  = mk(4'h0,    4'h0, 0,   3'd7, 0,   0, 0);
    tbl[9]  = mk(4'h0,    4'h0, 0,   3'd7, 3,   1, 1);
    tbl[10] = mk(4'b1000, 4'h0, 1,   3'd7, 2,   0, 0);
    tbl[11] = mk(4'h0,    4'h0, 0,   3'd7, 1,   0, 0);
    tbl[12] = mk(4'h0,    4'h0, 0,   3'd7, 0,   0, 0);
    tbl[13] = mk(4'b1000, 4'h0, 1,   3'd7, 3,   1, 1);
    tbl[14] = mk(4'h0,    4'h0, 0,   3'd7, 2,   1, 1);
    tbl[15] = mk(4'h0,    4'h0, 0,   3'd7, 1,   1, 1);
    tbl[16] = mk(4'h0,    4'h8, 0,   3'd7, 0,   1, 1);
    tbl[17] = mk(4'h0,    4'h0, 0,   3'd7, 3,   1, 1);
    tbl[18] = mk(4'h0,    4'h0, 0,   3'd7, 2,   1, 1);
    tbl[19] = mk(4'b0100, 4'h0, 100, 3'd7, 100, 1, 1);
    tbl[20] = mk(4'h0,    4'h0, 0,   3'd7, 99,  1, 1);
    tbl[21] = mk(4'b0100, 4'h8, 2,   3'd7, 2,   1, 1);
    tbl[22] = mk(4'b0001, 4'h0, 5,   3'd5, 1,   0, 0);
    tbl[23] = mk(4'h0,    4'h0, 0,   3'd5, 0,   0, 0);
    tbl[24] = mk(4'h0,    4'h0, 0,   3'd4, 0,   1, 1);
    tbl[25] = mk(4'h0,    4'h0, 0,   3'd4, 0,   1, 1);
    tbl[26] = mk(4'b1000, 4'h0, 1,   3'd4, 0,   0, 0);
    tbl[27] = mk(4'h0,    4'h0, 0,   3'd4, 0,   0, 0);
  end

  initial begin
    bit [3:0]  we, re;
    bit [31:0] d;
    reset_n = 1'b0;
    drive(4'h0, 4'h0, 32'h0);
    #1;
    do_reset();

    // Vector table on the PRESCALE=1 instance
    for (int i = 0; i < 28; i++) begin
      step(tbl[i].we, tbl[i].re, tbl[i].din);
      chk($sformatf("tbl%0d ctrl", i), if1.data_out[0],
          {29'h0, tbl[i].ctrl});
      chk($sformatf("tbl%0d count", i), if1.data_out[2],
          tbl[i].count);
      chk($sformatf("tbl%0d stat", i), if1.data_out[3],
          {31'h0, tbl[i].expd});
      chk($sformatf("tbl%0d irq", i), {31'h0, if1.irq_out},
          {31'h0, tbl[i].irq});
    end

    // PRESCALE=4, LOAD=1: expiry every 8 clocks
    do_reset();
    step(4'b0110, 4'h0, 1);
    step(4'b0001, 4'h0, 3);
    repeat (7) step(4'h0, 4'h0, 0);
    chk("p4 first pre", if4.data_out[3], 32'h0);
    step(4'h0, 4'h0, 0);
    chk("p4 first exp", if4.data_out[3], 32'h1);
    chk("p4 reload", if4.data_out[2], 32'h1);
    step(4'b1000, 4'h0, 1);
    chk("p4 wclr", if4.data_out[3], 32'h0);
    repeat (6) step(4'h0, 4'h0, 0);
    chk("p4 second pre", if4.data_out[3], 32'h0);
    step(4'h0, 4'h0, 0);
    chk("p4 second exp", if4.data_out[3], 32'h1);
    // Enable toggle restarts the prescaler phase
    step(4'h0, 4'h0, 0);
    step(4'b0001, 4'h0, 2);
    step(4'b0100, 4'h0, 0);
    step(4'b1000, 4'h0, 1);
    step(4'b0001, 4'h0, 3);
    repeat (3) step(4'h0, 4'h0, 0);
    chk("p4 restart pre", if4.data_out[3], 32'h0);
    step(4'h0, 4'h0, 0);
    chk("p4 restart exp", if4.data_out[3], 32'h1);

    // Async reset mid-count with expired and a pending clear
    step(4'b0110, 4'h0, 9);
    step(4'b0001, 4'h0, 7);
    repeat (12) step(4'h0, 4'h0, 0);
    step(4'h0, 4'h8, 0);
    chk("pre-rst exp", if1.data_out[3], {31'h0, m1.expd});
    chk("pre-rst irq", {31'h0, if1.irq_out}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst ctrl",  if1.data_out[0], 32'h0);
    chk("rst load",  if1.data_out[1], 32'h0);
    chk("rst count", if1.data_out[2], 32'h0);
    chk("rst stat",  if1.data_out[3], 32'h0);
    chk("rst irq",   {31'h0, if1.irq_out}, 32'h0);
    chk("rst4 load", if4.data_out[1], 32'h5);
    chk("rst4 count", if4.data_out[2], 32'h5);
    chk("rst4 stat", if4.data_out[3], 32'h0);
    m1 = mreset(32'h0);
    m4 = mreset(32'h5);
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 4; b++) begin
        we[b] = ($urandom_range(0, 7) == 0);
        re[b] = ($urandom_range(0, 5) == 0);
      end
      if ($urandom_range(0, 9) == 0) d = $urandom;
      else d = $urandom_range(0, 12);
      step(we, re, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
